view_trace_buffer: RTL and testbench

- Synthesizable, parametrised successor to the processor bench's value monitor.
- Watches CHANNELS probe buses (e.g. the CPU `view` word) and logs every value change into a FIFO, tagged with channel and timestamp.
- The host drains the FIFO through a read handshake.
- Capture holds off for a configurable settle time after arming, matching the post-reset stabilisation window used in simulation.

---
 rtl/view_trace_buffer.sv | 178 +++++++++++++++++
 tb/tb_view_trace_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/view_trace_buffer.sv
// Probe-bus change logger: records every value change on CHANNELS buses into a FIFO.
// Define VIEW_TRACE_TIMESTAMP_EN to add the capture timestamp to each entry.
module view_trace_buffer #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16,
    parameter int HOLDOFF  = 10,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      slow_clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] view_in,
    input  logic                      arm,
    input  logic                      rd_en,
    output logic                      rd_valid,
    output logic [WIDTH-1:0]          rd_data,
    output logic [CW-1:0]             rd_chan,
    output logic [TS_WIDTH-1:0]       rd_ts,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      capturing
);

    localparam int AW        = $clog2(DEPTH);
    localparam int HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int HOLD_LAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
`ifdef VIEW_TRACE_TIMESTAMP_EN
    localparam int EW = WIDTH + CW + TS_WIDTH;
`else
    localparam int EW = WIDTH + CW;
`endif

    typedef enum logic [1:0] {S_IDLE, S_HOLDOFF, S_CAPTURE} state_t;

    state_t              state, next_state;
    logic [HW-1:0]       hold_cnt;
    logic                first_cap;
    logic [WIDTH-1:0]    prev     [CHANNELS];
    logic [WIDTH-1:0]    snap_val [CHANNELS];
    logic [CHANNELS-1:0] pending, changed;
    logic [EW-1:0]       mem      [DEPTH];
    logic [EW-1:0]       head, wr_entry;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       sel;
    logic                sel_found, capture_en, full, wr_fire, rd_fire;
`ifdef VIEW_TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_now;
    logic [TS_WIDTH-1:0] snap_ts  [CHANNELS];
`endif

    always_comb begin
        next_state = state;
        if (!arm) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    next_state = (HOLDOFF == 0) ? S_CAPTURE : S_HOLDOFF;
                S_HOLDOFF: if (hold_cnt == HW'(HOLD_LAST)) next_state = S_CAPTURE;
                S_CAPTURE: next_state = S_CAPTURE;
                default:   next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge slow_clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            first_cap <= 1'b0;
        end else begin
            state     <= next_state;
            hold_cnt  <= (state == S_HOLDOFF) ? hold_cnt + 1'b1 : '0;
            first_cap <= (next_state == S_CAPTURE) && (state != S_CAPTURE);
        end
    end

    assign capturing  = (state == S_CAPTURE);
    assign capture_en = capturing && arm;
    assign full       = count[AW];
    assign rd_fire    = rd_en && (count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign wr_fire    = capture_en && sel_found && (!full || rd_fire);
    assign head       = mem[rd_ptr];

    always_comb begin
        changed   = '0;
        sel       = '0;
        sel_found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            changed[k] = capture_en && (first_cap || (view_in[k*WIDTH +: WIDTH] != prev[k]));
        end
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (pending[k]) begin
                sel       = CW'(k);
                sel_found = 1'b1;
            end
        end
    end

`ifdef VIEW_TRACE_TIMESTAMP_EN
    assign wr_entry = {snap_val[sel], sel, snap_ts[sel]};

    always_ff @(posedge slow_clk or negedge reset) begin
        if (!reset) ts_now <= '0;
        else        ts_now <= capture_en ? ts_now + 1'b1 : '0;
    end
`else
    assign wr_entry = {snap_val[sel], sel};
    assign rd_ts    = '0;
`endif

    // A re-change is only a loss if the old snapshot is not being written this cycle.
    always_ff @(posedge slow_clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            overflow <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                prev[k]     <= '0;
                snap_val[k] <= '0;
`ifdef VIEW_TRACE_TIMESTAMP_EN
                snap_ts[k]  <= '0;
`endif
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (!arm) begin
                    pending[k] <= 1'b0;
                end else if (changed[k]) begin
                    pending[k]  <= 1'b1;
                    snap_val[k] <= view_in[k*WIDTH +: WIDTH];
`ifdef VIEW_TRACE_TIMESTAMP_EN
                    snap_ts[k]  <= ts_now;
`endif
                    if (pending[k] && !(wr_fire && sel == CW'(k))) overflow <= 1'b1;
                end else if (wr_fire && sel == CW'(k)) begin
                    pending[k] <= 1'b0;
                end
                if (capture_en) prev[k] <= view_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge slow_clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge slow_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_chan  <= '0;
`ifdef VIEW_TRACE_TIMESTAMP_EN
            rd_ts    <= '0;
`endif
        end else begin
            rd_valid <= rd_fire;
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= head[EW-1 -: WIDTH];
                rd_chan <= head[EW-WIDTH-1 -: CW];
`ifdef VIEW_TRACE_TIMESTAMP_EN
                rd_ts   <= head[TS_WIDTH-1:0];
`endif
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_view_trace_buffer.sv
// Scoreboard bench for view_trace_buffer: directed probe changes, monitor checks every pop.
module tb_view_trace_buffer;

    localparam int WIDTH    = 32;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 16;
    localparam int TS_WIDTH = 16;
    localparam int HOLDOFF  = 10;

    logic                      slow_clk = 1'b0;
    logic                      reset;
    logic [CHANNELS*WIDTH-1:0] view_in;
    logic                      arm, rd_en;
    logic                      rd_valid;
    logic [WIDTH-1:0]          rd_data;
    logic [0:0]                rd_chan;
    logic [TS_WIDTH-1:0]       rd_ts;
    logic [$clog2(DEPTH):0]    count;
    logic                      overflow, capturing;

    view_trace_buffer #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH),
        .TS_WIDTH(TS_WIDTH), .HOLDOFF(HOLDOFF)
    ) dut (
        .slow_clk(slow_clk), .reset(reset), .view_in(view_in), .arm(arm),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_chan(rd_chan),
        .rd_ts(rd_ts), .count(count), .overflow(overflow), .capturing(capturing)
    );

    always #5 slow_clk = ~slow_clk;

    typedef struct {
        logic [WIDTH-1:0]    data;
        logic [0:0]          chan;
        logic [TS_WIDTH-1:0] ts;
    } entry_t;

    entry_t sb[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     cyc   = 0;
    int     cap0  = 0;

    function automatic logic [TS_WIDTH-1:0] exp_ts(input int t);
`ifdef VIEW_TRACE_TIMESTAMP_EN
        return TS_WIDTH'(t);
`else
        return '0;
`endif
    endfunction

    task automatic tick();
        @(posedge slow_clk);
        cyc++;
        @(negedge slow_clk);
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ts_goto(input int t);
        while (cyc - cap0 < t) tick();
    endtask

    task automatic arm_now();
        arm  = 1'b1;
        cap0 = cyc + HOLDOFF + 1;
    endtask

    // Drive a channel value so that it is sampled while the timestamp equals t.
    task automatic apply_stimulus(input int t, input int ch, input logic [WIDTH-1:0] v, input bit logged);
        ts_goto(t);
        view_in[ch*WIDTH +: WIDTH] = v;
        if (logged) sb.push_back('{data: v, chan: 1'(ch), ts: exp_ts(t)});
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
    endtask

    always @(negedge slow_clk) begin
        if (reset === 1'b1 && rd_valid === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("[TB] FAIL pop_unexpected: got chan %0d data %0h ts %0d, expected no entry",
                         rd_chan, rd_data, rd_ts);
            end else begin
                entry_t e;
                e = sb.pop_front();
                if ({rd_data, rd_chan, rd_ts} !== {e.data, e.chan, e.ts}) begin
                    n_err++;
                    $display("[TB] FAIL pop_entry: got chan %0d data %0h ts %0d, expected chan %0d data %0h ts %0d",
                             rd_chan, rd_data, rd_ts, e.chan, e.data, e.ts);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        reset   = 1'b0;
        arm     = 1'b0;
        rd_en   = 1'b0;
        view_in = {$urandom(), $urandom()};

        repeat (10) begin
            tick();
            view_in = {$urandom(), $urandom()};
        end
        check_output("reset_rd_valid",  rd_valid,  0);
        check_output("reset_rd_data",   rd_data,   0);
        check_output("reset_rd_chan",   rd_chan,   0);
        check_output("reset_rd_ts",     rd_ts,     0);
        check_output("reset_count",     count,     0);
        check_output("reset_overflow",  overflow,  0);
        check_output("reset_capturing", capturing, 0);

        view_in = {32'h0, 32'h1};
        reset   = 1'b1;
        tick();
        tick();
        check_output("idle_capturing", capturing, 0);

        arm_now();
        sb.push_back('{data: 32'h1, chan: 1'b0, ts: exp_ts(0)});
        sb.push_back('{data: 32'h0, chan: 1'b1, ts: exp_ts(0)});
        ts_goto(-1);
        check_output("holdoff_capturing_low", capturing, 0);
        tick();
        check_output("capture_start", capturing, 1);

        apply_stimulus(3, 0, 32'h5, 1);
        apply_stimulus(7, 0, 32'h9, 1);
        ts_goto(10);
        check_output("stable_no_log", count, 4);

        apply_stimulus(12, 0, 32'hA, 1);
        apply_stimulus(12, 1, 32'hB, 1);
        ts_goto(13);
        check_output("collision_pending", count, 4);
        ts_goto(14);
        check_output("collision_ch0_written", count, 5);
        ts_goto(15);
        check_output("collision_ch1_written", count, 6);
        check_output("collision_no_overflow", overflow, 0);

        pop_n(6);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_output("empty_read_ignored", rd_valid, 0);
        check_output("rd_data_hold", rd_data, 32'hB);
        check_output("rd_chan_hold", rd_chan, 1);
        check_output("drained_count", count, 0);
        check_output("drain1_complete", sb.size(), 0);

        // Twenty changes on ch0 with no reads; changes 17-19 are lost to overwrite.
        for (int i = 1; i <= 20; i++) begin
            ts_goto(30 + 2 * (i - 1));
            if (i == 18) begin
                check_output("full_saturate", count, 16);
                check_output("blocked_no_overflow", overflow, 0);
            end
            if (i == 19) check_output("blocked_overwrite_overflow", overflow, 1);
            apply_stimulus(30 + 2 * (i - 1), 0, 32'h100 + WIDTH'(i), (i <= 16) || (i == 20));
        end
        ts_goto(70);
        check_output("full_before_rw", count, 16);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_output("full_read_write", count, 16);
        tick();
        check_output("full_stable", count, 16);
        pop_n(16);
        check_output("full_drained_count", count, 0);
        tick();
        check_output("drain2_complete", sb.size(), 0);

        t0 = cyc - cap0 + 1;
        apply_stimulus(t0, 1, 32'hC0DE, 1);
        ts_goto(t0 + 3);
        arm = 1'b0;
        tick();
        check_output("disarm_capturing", capturing, 0);
        check_output("disarm_fifo_kept", count, 1);
        view_in[31:0] = 32'hDEAD;
        repeat (3) tick();
        check_output("disarm_no_log", count, 1);
        check_output("overflow_sticky", overflow, 1);
        pop_n(1);
        tick();
        check_output("drain3_complete", sb.size(), 0);

        reset = 1'b0;
        tick();
        check_output("rereset_overflow", overflow, 0);
        view_in = {32'h22, 32'h11};
        reset   = 1'b1;
        tick();
        arm_now();
        sb.push_back('{data: 32'h11, chan: 1'b0, ts: exp_ts(0)});
        sb.push_back('{data: 32'h22, chan: 1'b1, ts: exp_ts(0)});
        apply_stimulus(5, 0, 32'h33, 1);
        check_output("pre_repeat_overflow", overflow, 0);
        apply_stimulus(5, 1, 32'h44, 0);
        apply_stimulus(6, 1, 32'h55, 1);
        ts_goto(7);
        check_output("repeat_change_overflow", overflow, 1);
        ts_goto(8);
        check_output("overflow_latest_only", count, 4);
        pop_n(3);

        // Assert reset while the fourth entry is being presented.
        rd_en = 1'b1;
        @(posedge slow_clk);
        cyc++;
        #1;
        check_output("midread_rd_valid", rd_valid, 1);
        #1;
        reset = 1'b0;
        rd_en = 1'b0;
        #1;
        check_output("async_reset_rd_valid", rd_valid, 0);
        check_output("async_reset_count", count, 0);
        check_output("async_reset_capturing", capturing, 0);
        sb.delete();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check_output("post_reset_count", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
